// File: rtl/operand_fetch.sv
// Operand fetch: decodes LC-3 source selectors, absorbs the regfile's synchronous read and forwards writebacks.
// Latency: accept at edge T, operand bundle valid from T+1; peak rate one instruction every 2 cycles.
// Backpressure: bundle held stable while out_ready=0; in_ready=0 in READ, follows out_ready in VALID.
module operand_fetch #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    // decode-side handshake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    // writeback request
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_dr,
    input  logic [WIDTH-1:0] wb_data,
    // register file interface
    output logic [AW-1:0]    rf_sr1_sel,
    output logic [AW-1:0]    rf_sr2_sel,
    output logic [AW-1:0]    rf_dr_sel,
    output logic [WIDTH-1:0] rf_dr_in,
    output logic             rf_load_reg,
    input  logic [WIDTH-1:0] rf_sr1_out,
    input  logic [WIDTH-1:0] rf_sr2_out,
    // execute-side handshake
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_instr,
    output logic [AW-1:0]    out_dr,
    output logic [WIDTH-1:0] out_op1,
    output logic [WIDTH-1:0] out_op2
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_c;

    logic [15:0]        instr_q, instr_d;
    logic [AW-1:0]      sr1_q, sr1_d;
    logic [AW-1:0]      sr2_q, sr2_d;
    logic               byp1_q, byp1_d;
    logic               byp2_q, byp2_d;
    logic [WIDTH-1:0]   byp1_dat_q, byp1_dat_d;
    logic [WIDTH-1:0]   byp2_dat_q, byp2_dat_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   op2_q, op2_d;

    logic               is_store;
    logic               accept;
    logic               capture;
    logic               acc_hit1, acc_hit2;
    logic               cap_hit1, cap_hit2;

    // Stores (ST/STR/STI) read their source register from the DR field instead of SR2.
    assign is_store   = (in_instr[13:12] == 2'b11) && (in_instr[15:14] != 2'b11);
    assign rf_sr1_sel = AW'(in_instr[8:6]);
    assign rf_sr2_sel = is_store ? AW'(in_instr[11:9]) : AW'(in_instr[2:0]);

    // Writeback goes straight to the regfile write port with no added latency.
    assign rf_dr_sel   = wb_dr;
    assign rf_dr_in    = wb_data;
    assign rf_load_reg = wb_valid;

    assign in_ready  = in_ready_c;
    assign accept    = in_valid && in_ready_c;
    assign capture   = (state_q == S_READ);

    // At the accept edge the regfile samples the pre-write value, so a matching writeback must be remembered.
    assign acc_hit1  = wb_valid && (wb_dr == rf_sr1_sel);
    assign acc_hit2  = wb_valid && (wb_dr == rf_sr2_sel);
    // At the capture edge a matching writeback is newer than anything else we hold.
    assign cap_hit1  = wb_valid && (wb_dr == sr1_q);
    assign cap_hit2  = wb_valid && (wb_dr == sr2_q);

    assign out_valid = out_valid_q;
    assign out_instr = instr_q;
    assign out_dr    = AW'(instr_q[11:9]);
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // FSM next state, input ready and output valid.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        in_ready_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d     = S_VALID;
                out_valid_d = 1'b1;
            end
            S_VALID: begin
                // A new instruction may enter only in the cycle the held bundle leaves.
                in_ready_c = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = in_valid ? S_READ : S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath next state: latch on accept, resolve operands on capture.
    always_comb begin
        instr_d    = instr_q;
        sr1_d      = sr1_q;
        sr2_d      = sr2_q;
        byp1_d     = byp1_q;
        byp2_d     = byp2_q;
        byp1_dat_d = byp1_dat_q;
        byp2_dat_d = byp2_dat_q;
        op1_d      = op1_q;
        op2_d      = op2_q;

        if (accept) begin
            instr_d = in_instr;
            sr1_d   = rf_sr1_sel;
            sr2_d   = rf_sr2_sel;
            byp1_d  = acc_hit1;
            byp2_d  = acc_hit2;
            if (acc_hit1) begin
                byp1_dat_d = wb_data;
            end
            if (acc_hit2) begin
                byp2_dat_d = wb_data;
            end
        end

        if (capture) begin
            // Priority: writeback at this edge, then writeback seen at accept, then regfile read.
            if (cap_hit1) begin
                op1_d = wb_data;
            end else if (byp1_q) begin
                op1_d = byp1_dat_q;
            end else begin
                op1_d = rf_sr1_out;
            end

            if (cap_hit2) begin
                op2_d = wb_data;
            end else if (byp2_q) begin
                op2_d = byp2_dat_q;
            end else begin
                op2_d = rf_sr2_out;
            end

            byp1_d = 1'b0;
            byp2_d = 1'b0;
        end
    end

    // Datapath registers; reset discards any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            sr1_q      <= '0;
            sr2_q      <= '0;
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp1_dat_q <= '0;
            byp2_dat_q <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
        end else begin
            instr_q    <= instr_d;
            sr1_q      <= sr1_d;
            sr2_q      <= sr2_d;
            byp1_q     <= byp1_d;
            byp2_q     <= byp2_d;
            byp1_dat_q <= byp1_dat_d;
            byp2_dat_q <= byp2_dat_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural regfile, table of instruction vectors, scoreboard of expected bundles.
// Latency: checks out_valid one edge after accept; bundles checked when they leave (out_valid && out_ready).
// Backpressure: hand-written hold sequence with out_ready low, then back-to-back accept.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        wb_valid;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic [2:0]  rf_sr1_sel;
    logic [2:0]  rf_sr2_sel;
    logic [2:0]  rf_dr_sel;
    logic [15:0] rf_dr_in;
    logic        rf_load_reg;
    logic [15:0] rf_sr1_out;
    logic [15:0] rf_sr2_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [2:0]  out_dr;
    logic [15:0] out_op1;
    logic [15:0] out_op2;

    operand_fetch #(.WIDTH(16), .AW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .wb_valid    (wb_valid),
        .wb_dr       (wb_dr),
        .wb_data     (wb_data),
        .rf_sr1_sel  (rf_sr1_sel),
        .rf_sr2_sel  (rf_sr2_sel),
        .rf_dr_sel   (rf_dr_sel),
        .rf_dr_in    (rf_dr_in),
        .rf_load_reg (rf_load_reg),
        .rf_sr1_out  (rf_sr1_out),
        .rf_sr2_out  (rf_sr2_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_dr      (out_dr),
        .out_op1     (out_op1),
        .out_op2     (out_op2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous read of the pre-write value, write on load_reg.
    logic [15:0] regs [8];
    always @(posedge clk) begin
        rf_sr1_out <= regs[rf_sr1_sel];
        rf_sr2_out <= regs[rf_sr2_sel];
        if (rf_load_reg) regs[rf_dr_sel] <= rf_dr_in;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int n_fire = 0;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  dr;
        logic [15:0] op1;
        logic [15:0] op2;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [15:0] instr;
        logic        wbt_v;
        logic [2:0]  wbt_dr;
        logic [15:0] wbt_d;
        logic        wb1_v;
        logic [2:0]  wb1_dr;
        logic [15:0] wb1_d;
        logic [2:0]  e_sr1;
        logic [2:0]  e_sr2;
        logic [2:0]  e_dr;
        logic [15:0] e_op1;
        logic [15:0] e_op2;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] instr,
                                input logic wtv, input logic [2:0] wtr, input logic [15:0] wtd,
                                input logic w1v, input logic [2:0] w1r, input logic [15:0] w1d,
                                input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] dr,
                                input logic [15:0] o1, input logic [15:0] o2);
        vec_t v;
        v.instr = instr; v.wbt_v = wtv; v.wbt_dr = wtr; v.wbt_d = wtd;
        v.wb1_v = w1v; v.wb1_dr = w1r; v.wb1_d = w1d;
        v.e_sr1 = s1; v.e_sr2 = s2; v.e_dr = dr; v.e_op1 = o1; v.e_op2 = o2;
        return v;
    endfunction

    // Scoreboard: every bundle leaving the DUT must match the oldest expectation.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            n_fire++;
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_empty: unexpected bundle instr=%h op1=%h op2=%h", out_instr, out_op1, out_op2);
            end else begin
                e = sbq.pop_front();
                chk("out_instr", 32'(out_instr), 32'(e.instr));
                chk("out_dr",    32'(out_dr),    32'(e.dr));
                chk("out_op1",   32'(out_op1),   32'(e.op1));
                chk("out_op2",   32'(out_op2),   32'(e.op2));
            end
        end
    end

    // One instruction through IDLE -> READ -> VALID -> IDLE with writebacks at T and T+1.
    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_instr = v.instr; out_ready = 1'b1;
        wb_valid = v.wbt_v; wb_dr = v.wbt_dr; wb_data = v.wbt_d;
        #1;
        chk("in_ready_idle", 32'(in_ready),    32'd1);
        chk("sr1_sel",       32'(rf_sr1_sel),  32'(v.e_sr1));
        chk("sr2_sel",       32'(rf_sr2_sel),  32'(v.e_sr2));
        chk("rf_load_reg",   32'(rf_load_reg), 32'(v.wbt_v));
        chk("rf_dr_sel",     32'(rf_dr_sel),   32'(v.wbt_dr));
        chk("rf_dr_in",      32'(rf_dr_in),    32'(v.wbt_d));
        e.instr = v.instr; e.dr = v.e_dr; e.op1 = v.e_op1; e.op2 = v.e_op2;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; in_instr = 16'($urandom);
        wb_valid = v.wb1_v; wb_dr = v.wb1_dr; wb_data = v.wb1_d;
        #1;
        chk("out_valid_read", 32'(out_valid), 32'd0);
        chk("in_ready_read",  32'(in_ready),  32'd0);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        chk("out_valid_T1", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("out_valid_done", 32'(out_valid), 32'd0);
        chk("in_ready_done",  32'(in_ready),  32'd1);
    endtask

    initial begin
        exp_t e;
        // Register contents after preload: R2=1111, R5=2222, others C00n.
        vecs[0]  = mk(16'h1285, 0,3'd0,16'h0000, 0,3'd0,16'h0000, 3'd2,3'd5,3'd1, 16'h1111,16'h2222);
        vecs[1]  = mk(16'h1685, 1,3'd2,16'hBEEF, 0,3'd0,16'h0000, 3'd2,3'd5,3'd3, 16'hBEEF,16'h2222);
        vecs[2]  = mk(16'h1285, 0,3'd0,16'h0000, 1,3'd5,16'h0F0F, 3'd2,3'd5,3'd1, 16'hBEEF,16'h0F0F);
        vecs[3]  = mk(16'h1285, 1,3'd5,16'hAAAA, 1,3'd5,16'h5555, 3'd2,3'd5,3'd1, 16'hBEEF,16'h5555);
        vecs[4]  = mk(16'h7A80, 0,3'd0,16'h0000, 0,3'd0,16'h0000, 3'd2,3'd5,3'd5, 16'hBEEF,16'h5555);
        vecs[5]  = mk(16'h3E00, 1,3'd3,16'h3333, 0,3'd0,16'h0000, 3'd0,3'd7,3'd7, 16'hC000,16'hC007);
        vecs[6]  = mk(16'hB6C0, 1,3'd3,16'h4444, 0,3'd0,16'h0000, 3'd3,3'd3,3'd3, 16'h4444,16'h4444);
        vecs[7]  = mk(16'h1104, 1,3'd4,16'hAAAA, 1,3'd4,16'h1234, 3'd4,3'd4,3'd0, 16'h1234,16'h1234);
        vecs[8]  = mk(16'h5A7F, 0,3'd0,16'h0000, 1,3'd0,16'h0101, 3'd1,3'd7,3'd5, 16'hC001,16'hC007);
        vecs[9]  = mk(16'hF025, 1,3'd1,16'hC001, 0,3'd0,16'h0000, 3'd0,3'd5,3'd0, 16'h0101,16'h5555);
        vecs[10] = mk(16'h1285, 1,3'd2,16'h0A0A, 1,3'd5,16'h0B0B, 3'd2,3'd5,3'd1, 16'h0A0A,16'h0B0B);

        rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_dr = 3'd0; wb_data = 16'h0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_op1",   32'(out_op1),   32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wb_valid = 1'b1; wb_dr = 3'(i);
            wb_data = (i == 2) ? 16'h1111 : (i == 5) ? 16'h2222 : 16'hC000 + 16'(i);
        end
        @(negedge clk);
        wb_valid = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Hold under backpressure, writeback to R2 during VALID must not disturb the bundle.
        @(negedge clk);
        in_valid = 1'b1; in_instr = 16'h1685; out_ready = 1'b0;
        e.instr = 16'h1685; e.dr = 3'd3; e.op1 = 16'h0A0A; e.op2 = 16'h0B0B;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; in_instr = 16'hFFFF;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wb_valid = (i == 1); wb_dr = 3'd2; wb_data = 16'h7777;
            #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            chk("hold_op1",       32'(out_op1),   32'h0A0A);
            chk("hold_op2",       32'(out_op2),   32'h0B0B);
            @(negedge clk);
        end
        // Release with a new instruction waiting: back-to-back accept, writeback R1 at the accept edge.
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h1881;
        wb_valid = 1'b1; wb_dr = 3'd1; wb_data = 16'h9999;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        e.instr = 16'h1881; e.dr = 3'd4; e.op1 = 16'h7777; e.op2 = 16'h9999;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; wb_valid = 1'b0;
        #1;
        chk("b2b_gap_valid", 32'(out_valid), 32'd0);
        chk("b2b_gap_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        #1;
        chk("b2b_second_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("b2b_done_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while in READ discards the instruction.
        @(negedge clk);
        in_valid = 1'b1; in_instr = 16'h1285;
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n = 1'b0;
        wb_valid = 1'b1; wb_dr = 3'd6; wb_data = 16'h6666;
        #1;
        chk("arst_out_valid", 32'(out_valid),   32'd0);
        chk("arst_out_op1",   32'(out_op1),     32'd0);
        chk("arst_out_instr", 32'(out_instr),   32'd0);
        chk("arst_out_dr",    32'(out_dr),      32'd0);
        chk("arst_rf_load",   32'(rf_load_reg), 32'd1);
        chk("arst_rf_dr_sel", 32'(rf_dr_sel),   32'd6);
        chk("arst_rf_dr_in",  32'(rf_dr_in),    32'h6666);
        @(negedge clk);
        wb_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready",  32'(in_ready),  32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_no_bundle", 32'(out_valid), 32'd0);

        run_vec(mk(16'h1285, 0,3'd0,16'h0000, 0,3'd0,16'h0000, 3'd2,3'd5,3'd1, 16'h7777,16'h0B0B));

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("bundles",    32'(n_fire),     32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-read front end that drives the LC-3 register file.
- Accepts a decoded-stage instruction word over a valid/ready handshake and drives the regfile source selectors.
- Absorbs the regfile's one-cycle synchronous read latency and patches stale reads with in-flight writebacks.
- Presents both source operands plus the destination index to the execute stage over a second valid/ready handshake. It also owns the regfile write port, passing writeback traffic through.

Parameters:
- WIDTH, 16, register/operand data width
- AW, 3, register index width (8 registers)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready at a rising edge
- in_instr  in  16  LC-3 instruction word
- wb_valid  in  1  writeback request
- wb_dr  in  AW  writeback register index
- wb_data  in  WIDTH  writeback data
- rf_sr1_sel  out  AW  to regfile sr1_sel
- rf_sr2_sel  out  AW  to regfile sr2_sel
- rf_dr_sel  out  AW  to regfile dr_sel, equals wb_dr
- rf_dr_in  out  WIDTH  to regfile dr_in, equals wb_data
- rf_load_reg  out  1  to regfile load_reg, equals wb_valid
- rf_sr1_out  in  WIDTH  from regfile, data registered at previous edge
- rf_sr2_out  in  WIDTH  from regfile
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute stage accepts bundle
- out_instr  out  16  captured instruction
- out_dr  out  AW  in_instr[11:9] of captured instruction
- out_op1  out  WIDTH  SR1 operand
- out_op2  out  WIDTH  SR2 operand (or store source)

Behaviour:
- Selector decode, combinational from in_instr at all times:
  - rf_sr1_sel = in_instr[8:6].
  - rf_sr2_sel = in_instr[11:9] when opcode in_instr[15:12] is 0011 (ST), 0111 (STR) or 1011 (STI); otherwise in_instr[2:0].
- Writeback passthrough is purely combinational, with no added latency.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On accept at edge T: latch in_instr and the sr1/sr2 indices; go to READ.
  - READ:
    - in_ready=0.
    - At edge T+1: load out_op1/out_op2 from rf_sr1_out/rf_sr2_out, with the bypass rules below applied; set out_valid=1; go to VALID.
  - VALID:
    - Bundle is held stable while out_valid && !out_ready.
    - in_ready = out_ready.
    - On out fire with a simultaneous accept: go to READ with the new instruction; out_valid stays 1 only after the next capture, so it deasserts for one cycle.
    - On out fire without an accept: go to IDLE and clear out_valid.
- Latency: accept edge T, out_valid high from T+1. Maximum throughput is one instruction per 2 cycles.
- Bypass, at edge T (the accept edge):
  - The regfile reads the pre-write value, so the stale value must be corrected.
  - If wb_valid && wb_dr == sr1 index, set byp1=1 and latch wb_data.
  - Same for sr2 with byp2.
- Bypass, at edge T+1 (capture):
  - If wb_valid && wb_dr matches, use wb_data directly. This has the highest priority and also beats an edge-T bypass.
  - Else if byp is set, use the latched bypass data.
  - Else use rf_srN_out.
- Operand semantics:
  - Operands reflect every writeback up to and including the capture edge.
  - Writebacks during VALID do not alter a held bundle.
- If sr1 and sr2 indices are equal, both operands are bypassed identically.
- Reset (async, rst_n=0):
  - State to IDLE; clear out_valid, byp1 and byp2.
  - out_instr, out_dr, out_op1 and out_op2 go to 0.
  - An in-flight instruction is discarded.
  - rf_* passthrough outputs still follow their inputs.
- in_instr may change freely while in_ready=0; only the accepted value matters.

Test Plan:
- Preload R2=0x1111 and R5=0x2222 via wb. Accept ADD 0x1285 (DR=1, SR1=2, SR2=5) -> out_valid at T+1, out_op1=0x1111, out_op2=0x2222, out_dr=1.
- Accept ADD with SR1=R2 at edge T while wb writes R2=0xBEEF at the same edge -> out_op1=0xBEEF (edge-T bypass).
- Accept, then at edge T+1 wb writes R5=0x0F0F -> out_op2=0x0F0F. With wb writes R5=0xAAAA at T and R5=0x5555 at T+1 -> out_op2=0x5555.
- Accept STR 0x7A80 (src R5, base R2) -> rf_sr2_sel=5, out_op2 = R5 value.
- Hold out_ready=0 for 4 cycles with a wb to R2 during VALID -> bundle unchanged, in_ready=0. Raising out_ready with in_valid=1 gives back-to-back accept and out_valid low for exactly one cycle.
- Assert rst_n=0 asynchronously in READ -> out_valid=0 immediately, state IDLE, in_ready=1 after release.
